ex_muldiv_unit: RTL

Iterative RV32M multiply/divide engine in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the decoded M-extension operation (funct3E) and forwarded operands for the instruction held in EX. It raises a stall to the hazard unit while it iterates, then delivers a 32-bit result to the EX result mux for exactly one cycle.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/muldiv_signfix.sv | 28 ++
 rtl/ex_muldiv_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32M multiply/divide types: funct3 operation encodings, FSM states, iteration count.
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam int MD_ITER = 32;

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign helpers: 33-bit magnitudes of both operands and a 64-bit conditional negate.
module muldiv_signfix (
  input  logic [31:0] a_i,
  input  logic        a_signed_i,
  input  logic [31:0] b_i,
  input  logic        b_signed_i,
  input  logic [63:0] res_i,
  input  logic        res_neg_i,
  output logic [32:0] a_abs_o,
  output logic [32:0] b_abs_o,
  output logic        a_neg_o,
  output logic        b_neg_o,
  output logic [63:0] res_o
);

  function automatic logic [32:0] abs33(input logic [31:0] v, input logic s);
    logic [32:0] ext;
    ext = {s & v[31], v};
    return ext[32] ? (33'd0 - ext) : ext;
  endfunction

  assign a_abs_o = abs33(a_i, a_signed_i);
  assign b_abs_o = abs33(b_i, b_signed_i);
  assign a_neg_o = a_signed_i & a_i[31];
  assign b_neg_o = b_signed_i & b_i[31];
  assign res_o   = res_neg_i ? (64'd0 - res_i) : res_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine in EX: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to resolve multiplies in the start cycle with a single multiplier.
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MulDivE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            KillE,
  output logic            StallMD,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultMD
);

  md_state_e   state_q, state_d;
  muldiv_op_e  op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] a_q, a_d, b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  muldiv_op_e  op_s;
  logic        is_div_s, is_rem_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, neg_s;
  logic        div_zero_s, ovf_s, start_s;
  logic [32:0] a_abs_s, b_abs_s;
  logic [32:0] mul_sum_s, div_shift_s, div_diff_s;
  logic [63:0] step_acc_s, fin_acc_s, fix_in_s, fix_out_s;
  muldiv_op_e  fin_op_s;
  logic        fin_neg_s;
  logic [31:0] fin_result_s;

  assign op_s       = muldiv_op_e'(funct3E);
  assign is_div_s   = funct3E[2];
  assign is_rem_s   = funct3E[2] & funct3E[1];
  assign a_sgn_s    = (op_s == OP_MULH) | (op_s == OP_MULHSU) | (op_s == OP_DIV) | (op_s == OP_REM);
  assign b_sgn_s    = (op_s == OP_MULH) | (op_s == OP_DIV) | (op_s == OP_REM);
  // Remainder follows the dividend; everything else takes the product/quotient sign.
  assign neg_s      = is_rem_s ? a_neg_s : (a_neg_s ^ b_neg_s);
  assign div_zero_s = is_div_s & (SrcBE == 32'd0);
  assign ovf_s      = is_div_s & a_sgn_s & (SrcAE == 32'h8000_0000) & (SrcBE == 32'hFFFF_FFFF);
  assign start_s    = (state_q == MD_IDLE) & MulDivE & ~KillE;
  assign StallMD    = start_s | (state_q == MD_BUSY);
  assign DoneE      = done_q;
  assign ResultMD   = result_q;

  muldiv_signfix u_signfix (
    .a_i        (SrcAE),
    .a_signed_i (a_sgn_s),
    .b_i        (SrcBE),
    .b_signed_i (b_sgn_s),
    .res_i      (fix_in_s),
    .res_neg_i  (fin_neg_s),
    .a_abs_o    (a_abs_s),
    .b_abs_o    (b_abs_s),
    .a_neg_o    (a_neg_s),
    .b_neg_o    (b_neg_s),
    .res_o      (fix_out_s)
  );

  // One radix-2 step: acc holds {hi, lo} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[63:32]} + (acc_q[0] ? a_q : 33'd0);
    div_shift_s = {acc_q[63:32], acc_q[31]};
    div_diff_s  = div_shift_s - b_q;
    if (op_q[2]) begin
      if (div_diff_s[32]) begin
        step_acc_s = {div_shift_s[31:0], acc_q[30:0], 1'b0};
      end else begin
        step_acc_s = {div_diff_s[31:0], acc_q[30:0], 1'b1};
      end
    end else begin
      step_acc_s = {mul_sum_s, acc_q[31:1]};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod_s;
  assign fast_prod_s = 64'(a_abs_s) * 64'(b_abs_s);

  // In IDLE the result path sees the live operands so a multiply can finish at the start edge.
  always_comb begin
    if (state_q == MD_IDLE) begin
      fin_op_s  = op_s;
      fin_neg_s = neg_s;
      fin_acc_s = fast_prod_s;
    end else begin
      fin_op_s  = op_q;
      fin_neg_s = neg_q;
      fin_acc_s = step_acc_s;
    end
  end
`else
  assign fin_op_s  = op_q;
  assign fin_neg_s = neg_q;
  assign fin_acc_s = step_acc_s;
`endif

  // Pick the quotient/remainder half for divides, then the output word after sign correction.
  always_comb begin
    if (fin_op_s[2]) begin
      fix_in_s = {32'd0, (fin_op_s[1] ? fin_acc_s[63:32] : fin_acc_s[31:0])};
    end else begin
      fix_in_s = fin_acc_s;
    end
    if ((fin_op_s == OP_MUL) || fin_op_s[2]) begin
      fin_result_s = fix_out_s[31:0];
    end else begin
      fin_result_s = fix_out_s[63:32];
    end
  end

  // Next-state logic for the IDLE/BUSY/DONE sequencer and its datapath.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start_s) begin
          op_d  = op_s;
          a_d   = a_abs_s;
          b_d   = b_abs_s;
          neg_d = neg_s;
          cnt_d = 5'd0;
          acc_d = is_div_s ? {32'd0, a_abs_s[31:0]} : {32'd0, b_abs_s[31:0]};
          if (div_zero_s) begin
            state_d  = MD_DONE;
            result_d = is_rem_s ? SrcAE : 32'hFFFF_FFFF;
            done_d   = 1'b1;
          end else if (ovf_s) begin
            state_d  = MD_DONE;
            result_d = is_rem_s ? 32'd0 : 32'h8000_0000;
            done_d   = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div_s) begin
            state_d  = MD_DONE;
            result_d = fin_result_s;
            done_d   = 1'b1;
`endif
          end else begin
            state_d = MD_BUSY;
          end
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (KillE) begin
          state_d = MD_IDLE;
          cnt_d   = 5'd0;
        end else begin
          acc_d = step_acc_s;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(MD_ITER - 1)) begin
            state_d  = MD_DONE;
            result_d = fin_result_s;
            done_d   = 1'b1;
          end else begin
            state_d = MD_BUSY;
          end
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= 5'd0;
      a_q      <= 33'd0;
      b_q      <= 33'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule
